// File: rtl/pll_fracn_fb_divider_if.sv
// Control/status bundle for the fractional-N feedback divider.
// The master supplies enable and the division word; the slave returns the feedback timing outputs.
interface pll_fracn_fb_divider_if #(
  parameter int INT_WIDTH  = 4,
  parameter int FRAC_WIDTH = 4
);
  logic                   en;
  logic [INT_WIDTH-1:0]   int_div;
  logic [FRAC_WIDTH-1:0]  frac_div;
  logic                   div_pulse;
  logic                   div_clk;
  logic [INT_WIDTH+1:0]   cur_mod;
  logic                   clamp_err;

  modport master (
    output en, int_div, frac_div,
    input  div_pulse, div_clk, cur_mod, clamp_err
  );

  modport slave (
    input  en, int_div, frac_div,
    output div_pulse, div_clk, cur_mod, clamp_err
  );
endinterface

// File: rtl/pll_fracn_fb_divider.sv
// Fractional-N feedback divider: per-period modulus from a first-order accumulator
// or a MASH-1-1 modulator, with a one-cycle end-of-period pulse and a ~50% divided clock.
module pll_fracn_fb_divider #(
  parameter int INT_WIDTH  = 4,
  parameter int FRAC_WIDTH = 4,
  parameter int ORDER      = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  pll_fracn_fb_divider_if.slave bus
);
  localparam int MW      = INT_WIDTH + 2;
  localparam int MIN_MOD = 2;

  generate
    if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("pll_fracn_fb_divider: ORDER must be 1 or 2");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [MW-1:0]          cnt_q, cnt_d;
  logic [MW-1:0]          cur_mod_q, cur_mod_d;
  logic [FRAC_WIDTH-1:0]  acc1_q, acc1_d;
  logic [FRAC_WIDTH-1:0]  acc2_q, acc2_d;
  logic                   c2_prev_q, c2_prev_d;
  logic                   clamp_q, clamp_d;
  logic                   div_pulse_q, div_pulse_d;
  logic                   div_clk_q, div_clk_d;

  logic [FRAC_WIDTH:0]    s1, s2;
  logic [FRAC_WIDTH-1:0]  acc1_nx, acc2_nx;
  logic                   c1, c2;
  logic [MW-1:0]          off;
  logic [MW-1:0]          m_raw;
  logic [MW-1:0]          m_final;
  logic                   clamp_hit;
  logic                   load;

  // Modulus for the next period, evaluated every cycle but only committed on load.
  always_comb begin
    s1      = {1'b0, acc1_q} + {1'b0, bus.frac_div};
    c1      = s1[FRAC_WIDTH];
    acc1_nx = s1[FRAC_WIDTH-1:0];
    s2      = {1'b0, acc2_q} + {1'b0, acc1_nx};
    c2      = s2[FRAC_WIDTH];
    acc2_nx = s2[FRAC_WIDTH-1:0];
    if (ORDER == 2) begin
      off = MW'(c1) + MW'(c2) - MW'(c2_prev_q);
    end else begin
      off = MW'(c1);
    end
    m_raw     = {2'b00, bus.int_div} + off;
    clamp_hit = $signed(m_raw) < $signed(MW'(MIN_MOD));
    m_final   = clamp_hit ? MW'(MIN_MOD) : m_raw;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_mod_d = cur_mod_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    c2_prev_d = c2_prev_q;
    clamp_d   = clamp_q;
    load      = 1'b0;

    if (!bus.en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      cur_mod_d = '0;
      acc1_d    = '0;
      acc2_d    = '0;
      c2_prev_d = 1'b0;
      clamp_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE:    load = 1'b1;
        RUN: begin
          if (cnt_q == '0) load = 1'b1;
          else             cnt_d = cnt_q - MW'(1);
        end
        default: load = 1'b1;
      endcase

      if (load) begin
        state_d   = RUN;
        cnt_d     = m_final - MW'(1);
        cur_mod_d = m_final;
        acc1_d    = acc1_nx;
        if (ORDER == 2) begin
          acc2_d    = acc2_nx;
          c2_prev_d = c2;
        end
        clamp_d   = clamp_q | clamp_hit;
      end
    end

    // Outputs are registered from next-state so they toggle cleanly on the clock edge.
    div_pulse_d = (state_d == RUN) && (cnt_d == '0);
    div_clk_d   = (state_d == RUN) && (cnt_d >= (cur_mod_d >> 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_mod_q   <= '0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      c2_prev_q   <= 1'b0;
      clamp_q     <= 1'b0;
      div_pulse_q <= 1'b0;
      div_clk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_mod_q   <= cur_mod_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      c2_prev_q   <= c2_prev_d;
      clamp_q     <= clamp_d;
      div_pulse_q <= div_pulse_d;
      div_clk_q   <= div_clk_d;
    end
  end

  assign bus.div_pulse = div_pulse_q;
  assign bus.div_clk   = div_clk_q;
  assign bus.cur_mod   = cur_mod_q;
  assign bus.clamp_err = clamp_q;
endmodule

// File: doc/pll_fracn_fb_divider.md
Name: pll_fracn_fb_divider

Overview:
- Fractional-N feedback divider for the PLL model. Runs on the VCO clock and produces the divided feedback pulse/clock that the phase detector compares against clk_ref.
- The modulus is set per output period by a first-order accumulator or a MASH-1-1 sigma-delta modulator.
- Average division ratio = int_div + frac_div/2^FRAC_WIDTH.
- Synthesizable. Intended to replace the behavioural divide inside pll_model and to be reused standalone.

Parameters:
- INT_WIDTH, 4, width of int_div.
- FRAC_WIDTH, 4, width of frac_div and of each accumulator.
- ORDER, 1, modulator order. 1 = single accumulator; 2 = MASH-1-1. Any other value is a compile-time error.

Ports:
- clk  in  1  VCO clock; all logic is on posedge.
- rstn  in  1  async active-low reset.
- en  in  1  divider enable; low clears state synchronously.
- int_div  in  INT_WIDTH  integer division part; sampled only at period boundaries.
- frac_div  in  FRAC_WIDTH  fractional numerator over 2^FRAC_WIDTH; sampled only at period boundaries.
- div_pulse  out  1  one-clk pulse on the last cycle of each feedback period.
- div_clk  out  1  divided clock, high for the first ceil(M/2) cycles of each period.
- cur_mod  out  INT_WIDTH+2  modulus M of the period currently running.
- clamp_err  out  1  sticky flag: the requested modulus was clamped.

Behaviour:
- Reset (rstn=0, async): state=IDLE, cnt=0, acc1=acc2=0, c2_prev=0. Outputs div_pulse=0, div_clk=0, cur_mod=0, clamp_err=0.
- States: IDLE, RUN.
- IDLE:
  - Outputs held at reset values.
  - On the first clk with en=1: compute modulus M0 (below), load cnt=M0-1, cur_mod=M0, go to RUN.
- RUN, each clk:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: div_pulse=1 this cycle. On the same edge, compute the next M, load cnt=M-1, cur_mod=M.
  - Result: div_pulse period is exactly M clk cycles. The first pulse occurs M0 cycles after leaving IDLE.
- Modulus computation (at the IDLE->RUN edge and at each cnt==0 edge):
  - Sample int_div and frac_div.
  - s1 = acc1 + frac_div (FRAC_WIDTH+1 bits); c1 = s1 MSB; acc1 <= s1 low bits.
  - ORDER=1: off = c1, range 0..1.
  - ORDER=2:
    - s2 = acc2 + new acc1; c2 = carry; acc2 <= low bits.
    - off = c1 + c2 - c2_prev, range -1..+2; c2_prev <= c2.
  - M = int_div + off, signed arithmetic with INT_WIDTH+2-bit result.
- Clamp:
  - MIN_MOD = 2.
  - If M < MIN_MOD: M := MIN_MOD and clamp_err <= 1.
  - clamp_err stays sticky until en=0 or reset.
- div_clk = 1 when cnt >= (cur_mod >> 1). It is derived from registered state only, so it is glitch-free.
  - Odd M: high for ceil(M/2) cycles.
  - M=2: one cycle high, one cycle low.
- en=0 while in RUN: on the next clk, synchronously return to IDLE with all state at reset values. Any partial period is discarded.
- Inputs changing mid-period have no effect until the next boundary.
- Reset mid-period: outputs go to reset values immediately (async). Restart begins from IDLE.
- frac_div=0: M = int_div every period; accumulators stay 0.
- Accumulator wrap is modulo 2^FRAC_WIDTH and is intentional; no saturation.
- Average ratio:
  - ORDER=1: the sum of M over any 2^FRAC_WIDTH consecutive periods is exactly 2^FRAC_WIDTH*int_div + frac_div.
  - ORDER=2: the same sum is exact within ±1.

Test Plan:
1. ORDER=1, int_div=12, frac_div=10, FRAC_WIDTH=4, en=1 after reset -> cur_mod sequence is 12,13,12,13,13,12,13,13 and then repeats. The div_pulse spacing matches cur_mod. Over 16 periods the total is 202 clk cycles (average 12.625).
2. ORDER=2, same settings, 1600 periods -> every M is in 11..14. Total cycles = 20200 ±1. With a 100 MHz clk_ref loop, the measured fout is within 0.1% of 1.2625 GHz.
3. int_div=5, frac_div=0 -> constant M=5. div_clk is high 3 cycles, low 2 cycles. clamp_err=0.
4. ORDER=2, int_div=2, frac_div=1 -> any period computing M=1 is clamped to 2 and clamp_err=1. Driving en low then high clears clamp_err.
5. Change int_div 12->7 while cnt=6 -> the current period still completes at the old M. The next cur_mod reflects 7+off.
6. Assert rstn=0 mid-period, then en=0 mid-period -> reset: outputs are 0 asynchronously. en=0: IDLE on the next clk. On restart the first pulse is exactly M0 cycles after en is seen high.
